// File: rtl/amci_arbiter.sv
// amci_arbiter: shares one AMCI write/read master port pair among NUM_REQ requesters.
// Each requester owns a one-deep slot per direction; the write and read paths are round-robin arbitrated independently.

module amci_arb_lane #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_stb,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_done,
    input  logic [1:0]    wr_resp_in,
    output logic          wr_pend,
    output logic          wr_idle,
    output logic [AW-1:0] wr_slot_addr,
    output logic [DW-1:0] wr_slot_data,
    output logic [1:0]    wr_resp,
    input  logic          rd_stb,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_done,
    input  logic [1:0]    rd_resp_in,
    input  logic [DW-1:0] rd_data_in,
    output logic          rd_pend,
    output logic          rd_idle,
    output logic [AW-1:0] rd_slot_addr,
    output logic [1:0]    rd_resp,
    output logic [DW-1:0] rd_data
);

    // Capture needs idle and done needs pending, so the two never coincide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_pend      <= 1'b0;
            wr_idle      <= 1'b1;
            wr_slot_addr <= '0;
            wr_slot_data <= '0;
            wr_resp      <= '0;
        end else if (wr_stb && wr_idle) begin
            wr_pend      <= 1'b1;
            wr_idle      <= 1'b0;
            wr_slot_addr <= wr_addr;
            wr_slot_data <= wr_data;
        end else if (wr_done) begin
            wr_pend      <= 1'b0;
            wr_idle      <= 1'b1;
            wr_resp      <= wr_resp_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pend      <= 1'b0;
            rd_idle      <= 1'b1;
            rd_slot_addr <= '0;
            rd_resp      <= '0;
            rd_data      <= '0;
        end else if (rd_stb && rd_idle) begin
            rd_pend      <= 1'b1;
            rd_idle      <= 1'b0;
            rd_slot_addr <= rd_addr;
        end else if (rd_done) begin
            rd_pend      <= 1'b0;
            rd_idle      <= 1'b1;
            rd_resp      <= rd_resp_in;
            rd_data      <= rd_data_in;
        end
    end

endmodule

module amci_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ*AW-1:0] req_waddr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_write,
    output logic [NUM_REQ*2-1:0]  req_wresp,
    output logic [NUM_REQ-1:0]    req_widle,
    input  logic [NUM_REQ*AW-1:0] req_raddr,
    input  logic [NUM_REQ-1:0]    req_read,
    output logic [NUM_REQ*DW-1:0] req_rdata,
    output logic [NUM_REQ*2-1:0]  req_rresp,
    output logic [NUM_REQ-1:0]    req_ridle,
    output logic [AW-1:0]         amci_waddr,
    output logic [DW-1:0]         amci_wdata,
    output logic                  amci_write,
    input  logic [1:0]            amci_wresp,
    input  logic                  amci_widle,
    output logic [AW-1:0]         amci_raddr,
    output logic                  amci_read,
    input  logic [DW-1:0]         amci_rdata,
    input  logic [1:0]            amci_rresp,
    input  logic                  amci_ridle
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    state_t                       wstate, rstate;
    logic [IW-1:0]                wptr, rptr, wgnt, rgnt;
    logic [IW:0]                  wsel, rsel;
    logic [NUM_REQ-1:0]           wpend, rpend, wdone, rdone;
    logic [NUM_REQ-1:0][AW-1:0]   wslot_addr, rslot_addr;
    logic [NUM_REQ-1:0][DW-1:0]   wslot_data;

    // {found, index} of the first pending requester at or after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] pend, input logic [IW-1:0] ptr);
        logic [IW:0]   res;
        logic [IW-1:0] j;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            j = IW'(idx);
            if (pend[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
        return (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
    endfunction

    assign wsel = rr_pick(wpend, wptr);
    assign rsel = rr_pick(rpend, rptr);

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
            assign wdone[i] = (wstate == S_WAIT) && amci_widle && (wgnt == IW'(i));
            assign rdone[i] = (rstate == S_WAIT) && amci_ridle && (rgnt == IW'(i));

            amci_arb_lane #(.AW(AW), .DW(DW)) u_lane (
                .clk          (clk),
                .resetn       (resetn),
                .wr_stb       (req_write[i]),
                .wr_addr      (req_waddr[i*AW +: AW]),
                .wr_data      (req_wdata[i*DW +: DW]),
                .wr_done      (wdone[i]),
                .wr_resp_in   (amci_wresp),
                .wr_pend      (wpend[i]),
                .wr_idle      (req_widle[i]),
                .wr_slot_addr (wslot_addr[i]),
                .wr_slot_data (wslot_data[i]),
                .wr_resp      (req_wresp[i*2 +: 2]),
                .rd_stb       (req_read[i]),
                .rd_addr      (req_raddr[i*AW +: AW]),
                .rd_done      (rdone[i]),
                .rd_resp_in   (amci_rresp),
                .rd_data_in   (amci_rdata),
                .rd_pend      (rpend[i]),
                .rd_idle      (req_ridle[i]),
                .rd_slot_addr (rslot_addr[i]),
                .rd_resp      (req_rresp[i*2 +: 2]),
                .rd_data      (req_rdata[i*DW +: DW])
            );
        end
    endgenerate

    // LAUNCH is a guard cycle so the master's idle has time to fall before WAIT looks at it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate     <= S_IDLE;
            wptr       <= '0;
            wgnt       <= '0;
            amci_write <= 1'b0;
            amci_waddr <= '0;
            amci_wdata <= '0;
        end else begin
            amci_write <= 1'b0;
            case (wstate)
                S_IDLE: if (wsel[IW] && amci_widle) begin
                    wgnt       <= wsel[IW-1:0];
                    amci_waddr <= wslot_addr[wsel[IW-1:0]];
                    amci_wdata <= wslot_data[wsel[IW-1:0]];
                    amci_write <= 1'b1;
                    wstate     <= S_LAUNCH;
                end
                S_LAUNCH: wstate <= S_WAIT;
                S_WAIT: if (amci_widle) begin
                    wptr   <= rr_next(wgnt);
                    wstate <= S_IDLE;
                end
                default: wstate <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate     <= S_IDLE;
            rptr       <= '0;
            rgnt       <= '0;
            amci_read  <= 1'b0;
            amci_raddr <= '0;
        end else begin
            amci_read <= 1'b0;
            case (rstate)
                S_IDLE: if (rsel[IW] && amci_ridle) begin
                    rgnt       <= rsel[IW-1:0];
                    amci_raddr <= rslot_addr[rsel[IW-1:0]];
                    amci_read  <= 1'b1;
                    rstate     <= S_LAUNCH;
                end
                S_LAUNCH: rstate <= S_WAIT;
                S_WAIT: if (amci_ridle) begin
                    rptr   <= rr_next(rgnt);
                    rstate <= S_IDLE;
                end
                default: rstate <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/amci_arbiter.md
Name: amci_arbiter

Overview:
- Shares one axi4_lite_master AMCI port pair (write and read) among NUM_REQ requesters, e.g. traffic generators and status pollers.
- Each requester sees a private AMCI-style interface.
- The arbiter buffers one request per requester, serialises requests onto the shared master with round-robin fairness, and returns response, data and idle per requester.
- Write and read paths are arbitrated independently.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
AW, 32, AXI address width
DW, 32, AXI data width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_waddr  in  NUM_REQ*AW  per-requester write address, slice i = requester i
req_wdata  in  NUM_REQ*DW  per-requester write data
req_write  in  NUM_REQ  per-requester write strobe
req_wresp  out  NUM_REQ*2  per-requester BRESP of last completed write
req_widle  out  NUM_REQ  requester may issue a write
req_raddr  in  NUM_REQ*AW  per-requester read address
req_read  in  NUM_REQ  per-requester read strobe
req_rdata  out  NUM_REQ*DW  per-requester last read data
req_rresp  out  NUM_REQ*2  per-requester RRESP of last completed read
req_ridle  out  NUM_REQ  requester may issue a read
amci_waddr  out  AW  to master AMCI_WADDR
amci_wdata  out  DW  to master AMCI_WDATA
amci_write  out  1  to master AMCI_WRITE (one-cycle pulse)
amci_wresp  in  2  from master AMCI_WRESP
amci_widle  in  1  from master AMCI_WIDLE
amci_raddr  out  AW  to master AMCI_RADDR
amci_read  out  1  to master AMCI_READ (one-cycle pulse)
amci_rdata  in  DW  from master AMCI_RDATA
amci_rresp  in  2  from master AMCI_RRESP
amci_ridle  in  1  from master AMCI_RIDLE

Behaviour:
- All outputs are registered.
- Asynchronous reset (resetn=0) sets:
  - pending flags = 0
  - req_widle, req_ridle = all ones
  - req_wresp, req_rresp, req_rdata = 0
  - amci_write, amci_read = 0
  - amci_waddr, amci_wdata, amci_raddr = 0
  - round-robin pointers = 0
  - both FSMs = IDLE
- Reset mid-transaction abandons the transaction. The shared master is reset by the same resetn.
- Write capture: req_write[i]=1 while req_widle[i]=1 latches the addr/data slice into slot i and sets pending[i]. req_widle[i] drops the next cycle.
- A strobe while req_widle[i]=0 is ignored and does not overwrite slot i.
- Write FSM:
  - IDLE: if any pending and amci_widle=1, grant g = first pending index at or after wptr, wrapping modulo NUM_REQ. Drive amci_waddr/amci_wdata from slot g and pulse amci_write for exactly one cycle -> LAUNCH.
  - LAUNCH: one guard cycle; amci_widle is not examined -> WAIT.
  - WAIT: on amci_widle=1: req_wresp[g] <= amci_wresp, pending[g] <= 0, req_widle[g] <= 1, wptr <= (g+1) mod NUM_REQ -> IDLE.
- Read path is identical (rptr, LAUNCH/WAIT) and additionally sets req_rdata[g] <= amci_rdata at completion.
- Latency: a strobe at cycle t (arbiter idle, master idle) gives amci_write high at t+2, because capture takes one cycle and grant/issue one more.
- A requester's idle rises the cycle after completion. A new strobe in that cycle is accepted.
- A captured request is held indefinitely while amci_widle=0. Nothing is dropped.
- Simultaneous strobes: all are captured in the same cycle and served in round-robin order from the pointer.
- A request arriving during another's service waits. It is granted on the IDLE after completion. No requester waits more than NUM_REQ-1 services.
- A write and a read may be in flight to the master at once, from the same or different requesters.
- Only the granted requester's req_wresp/req_rresp/req_rdata change. Others hold their last values.

Test Plan:
- Single write: req0 writes addr 0x4000_0000, data 0x5 -> one amci_write pulse 2 cycles later with those values. Slave BRESP=2'b00 -> req_wresp[0]=0, req_widle[0]=1. No pulse for req1.
- Simultaneous writes: req0 and req1 strobe the same cycle, wptr=0 -> req0 served first, then req1. Exactly two pulses, never overlapping. Final wptr=0.
- Fairness: req0 strobes again each time its idle rises; req1 strobes once -> req1 is served within one req0 service.
- Read under backpressure: slave holds ARREADY low 20 cycles; req1 reads 0x10, slave returns 0xDEADBEEF, RRESP=2'b10 -> req_rdata[1]=0xDEADBEEF, req_rresp[1]=2, req_ridle[1] low throughout; req0 outputs unchanged.
- Concurrency and illegal strobe: req0 write and req1 read in the same cycle -> amci_write and amci_read pulse together. A second req0 strobe while busy is ignored (single write issued).
- Reset mid-WAIT: deassert resetn during an outstanding write -> immediately all idles=1, amci_write=0, pending cleared. After release, a fresh write completes normally.
